// File: rtl/serial_pkg.sv
// Shared serial-link definitions: state encoding, default sync header and
// small elaboration-time helpers used by the transmitter and the detectors.
package serial_pkg;

  // State encoding shared with anything that decodes the transmitter state.
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SYNC = 2'd1;
  localparam logic [1:0] DATA = 2'd2;
  localparam logic [1:0] GAP  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = IDLE,
    ST_SYNC = SYNC,
    ST_DATA = DATA,
    ST_GAP  = GAP
  } tx_state_e;

  // Default frame header, shared with the serial sequence detectors.
  localparam int         SYNC_W_DEFAULT       = 4;
  localparam logic [3:0] SYNC_PATTERN_DEFAULT = 4'b1011;

  // Largest of three lengths; sizes the shared bit counter.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/sync_frame_tx_piso_shift.sv
// Parallel-load, MSB-first shift register holding the payload of the frame
// currently being sent. Load wins over shift if both are asserted.
module piso_shift #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              shift,
  input  logic [DATA_W-1:0] d,
  output logic              q_msb
);

  logic [DATA_W-1:0] sr_q;

  // Capture the payload on load, otherwise move the next bit up to the MSB.
  always_ff @(posedge clk) begin
    if (reset) begin
      sr_q <= '0;
    end else if (load) begin
      sr_q <= d;
    end else if (shift) begin
      sr_q <= sr_q << 1;
    end
  end

  assign q_msb = sr_q[DATA_W-1];

endmodule

// File: rtl/sync_frame_tx.sv
// Serial frame transmitter. A payload word accepted over valid/ready is sent
// on a single registered line as: sync header (MSB first), payload (MSB
// first), then GAP_CYCLES forced zeros. One bit per clock.
//
// Handshake: a word is accepted at a rising edge where in_valid && in_ready.
// in_ready is high exactly while the FSM is in IDLE and is registered, so
// there is no combinational path from in_* to any output. in_valid/in_data
// are ignored while a frame is in flight.
module sync_frame_tx
  import serial_pkg::*;
#(
  parameter int                DATA_W       = 8,
  parameter int                SYNC_W       = SYNC_W_DEFAULT,
  parameter logic [SYNC_W-1:0] SYNC_PATTERN = SYNC_PATTERN_DEFAULT,
  parameter int                GAP_CYCLES   = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out,
  output logic              sync_active,
  output logic              busy,
  output logic              done
);

  localparam int CNT_W = $clog2(max3(SYNC_W, DATA_W, GAP_CYCLES) + 1);

  // Counter holds the number of bits still to send in the current state
  // after the one on the line now; it reloads on every state change.
  localparam logic [CNT_W-1:0] SYNC_LAST = CNT_W'(SYNC_W - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  tx_state_e         state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [SYNC_W-1:0] sync_sr_q;
  logic              out_q;
  logic              sync_active_q;
  logic              busy_q;
  logic              in_ready_q;
  logic              done_q;

  logic accept;
  logic pay_shift;
  logic pay_msb;
  logic cnt_zero;

  assign accept   = in_valid && in_ready_q && (state_q == ST_IDLE);
  assign cnt_zero = (cnt_q == '0);

  // A payload bit leaves the register on the SYNC->DATA edge and on every
  // DATA edge except the last one.
  assign pay_shift = ((state_q == ST_SYNC) && cnt_zero) ||
                     ((state_q == ST_DATA) && !cnt_zero);

  piso_shift #(
    .DATA_W (DATA_W)
  ) u_piso (
    .clk   (clk),
    .reset (reset),
    .load  (accept),
    .shift (pay_shift),
    .d     (in_data),
    .q_msb (pay_msb)
  );

  // Frame FSM with bit counter and registered line/status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      sync_sr_q     <= '0;
      out_q         <= 1'b0;
      sync_active_q <= 1'b0;
      busy_q        <= 1'b0;
      in_ready_q    <= 1'b1;
      done_q        <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            state_q       <= ST_SYNC;
            cnt_q         <= SYNC_LAST;
            out_q         <= SYNC_PATTERN[SYNC_W-1];
            sync_sr_q     <= SYNC_PATTERN << 1;
            sync_active_q <= 1'b1;
            busy_q        <= 1'b1;
            in_ready_q    <= 1'b0;
          end
        end
        ST_SYNC: begin
          if (cnt_zero) begin
            state_q       <= ST_DATA;
            cnt_q         <= DATA_LAST;
            out_q         <= pay_msb;
            sync_active_q <= 1'b0;
          end else begin
            cnt_q     <= cnt_q - CNT_ONE;
            out_q     <= sync_sr_q[SYNC_W-1];
            sync_sr_q <= sync_sr_q << 1;
          end
        end
        ST_DATA: begin
          if (cnt_zero) begin
            out_q <= 1'b0;
            if (GAP_CYCLES > 0) begin
              state_q <= ST_GAP;
              cnt_q   <= GAP_LAST;
            end else begin
              state_q    <= ST_IDLE;
              cnt_q      <= '0;
              busy_q     <= 1'b0;
              in_ready_q <= 1'b1;
              done_q     <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
            out_q <= pay_msb;
          end
        end
        ST_GAP: begin
          out_q <= 1'b0;
          if (cnt_zero) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            busy_q     <= 1'b0;
            in_ready_q <= 1'b1;
            done_q     <= 1'b1;
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end
        default: begin
          state_q    <= ST_IDLE;
          cnt_q      <= '0;
          out_q      <= 1'b0;
          busy_q     <= 1'b0;
          in_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign out         = out_q;
  assign sync_active = sync_active_q;
  assign busy        = busy_q;
  assign in_ready    = in_ready_q;
  assign done        = done_q;

endmodule

// File: tb/tb_sync_frame_tx.sv
// Bench for sync_frame_tx. Instance u_a uses GAP_CYCLES=2, u_b uses
// GAP_CYCLES=0. A frame-position model (bit index within the frame) predicts
// every output each cycle; spec-level bit strings are checked on top of it.
module tb_sync_frame_tx;

  localparam int         DW    = 8;
  localparam int         SW    = 4;
  localparam int         LEN_A = SW + DW + 2;
  localparam int         LEN_B = SW + DW + 0;
  localparam logic [3:0] PAT   = 4'b1011;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic       va, ra, oa, sa, ba, dna;
  logic [7:0] da;
  logic       vb, rb, ob, sb, bb, dnb;
  logic [7:0] db;

  sync_frame_tx #(.DATA_W(8), .SYNC_W(4), .SYNC_PATTERN(4'b1011), .GAP_CYCLES(2)) u_a (
    .clk(clk), .reset(reset), .in_valid(va), .in_ready(ra), .in_data(da),
    .out(oa), .sync_active(sa), .busy(ba), .done(dna)
  );

  sync_frame_tx #(.DATA_W(8), .SYNC_W(4), .SYNC_PATTERN(4'b1011), .GAP_CYCLES(0)) u_b (
    .clk(clk), .reset(reset), .in_valid(vb), .in_ready(rb), .in_data(db),
    .out(ob), .sync_active(sb), .busy(bb), .done(dnb)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // ---------------- reference model ----------------
  // pos = 0 when idle, else 1-based index of the bit currently on the line.
  int         pos_a = 0, pos_b = 0;
  logic [7:0] md_a = '0, md_b = '0;
  logic       mdone_a = 1'b0, mdone_b = 1'b0;

  function automatic logic fbit(input logic [7:0] d, input int p);
    logic [3:0] pat;
    pat = PAT;
    if (p >= 1 && p <= SW) return pat[SW - p];
    if (p > SW && p <= SW + DW) return d[DW - (p - SW)];
    return 1'b0;
  endfunction

  // Expected {out, in_ready, busy, sync_active, done}.
  function automatic logic [4:0] expv(input int p, input logic [7:0] d, input logic dn);
    return {fbit(d, p), (p == 0), (p != 0), (p >= 1 && p <= SW), dn};
  endfunction

  task automatic tick();
    @(posedge clk);
    if (reset) begin
      pos_a = 0; mdone_a = 1'b0; pos_b = 0; mdone_b = 1'b0;
    end else begin
      if (pos_a == 0) begin
        mdone_a = 1'b0;
        if (va) begin md_a = da; pos_a = 1; end
      end else if (pos_a == LEN_A) begin
        pos_a = 0; mdone_a = 1'b1;
      end else begin
        pos_a++;
      end
      if (pos_b == 0) begin
        mdone_b = 1'b0;
        if (vb) begin md_b = db; pos_b = 1; end
      end else if (pos_b == LEN_B) begin
        pos_b = 0; mdone_b = 1'b1;
      end else begin
        pos_b++;
      end
    end
    @(negedge clk);
    cyc++;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1; va = 1'b1; vb = 1'b1;
    da = 8'($urandom); db = 8'($urandom);
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if ({oa, ra, ba, sa, dna} !== 5'b01000) begin
        errors++;
        $display("FAIL reset_a cyc=%0d got %b want 01000", cyc, {oa, ra, ba, sa, dna});
      end
      checks++;
      if ({ob, rb, bb, sb, dnb} !== 5'b01000) begin
        errors++;
        $display("FAIL reset_b cyc=%0d got %b want 01000", cyc, {ob, rb, bb, sb, dnb});
      end
    end
    reset = 1'b0; va = 1'b0; vb = 1'b0;
    tick();
    checks++;
    if ({oa, ra, ba, sa, dna} !== 5'b01000) begin
      errors++;
      $display("FAIL reset_release cyc=%0d got %b want 01000", cyc, {oa, ra, ba, sa, dna});
    end
  endtask

  task automatic test_single();
    logic [13:0] stream;
    int          done_cyc;
    stream = '0; done_cyc = -1;
    va = 1'b1; da = 8'hA5;
    tick();
    va = 1'b0; da = 8'($urandom);
    for (int c = 1; c <= 16; c++) begin
      checks++;
      if ({oa, ra, ba, sa, dna} !== expv(pos_a, md_a, mdone_a)) begin
        errors++;
        $display("FAIL single c=%0d got %b want %b", c, {oa, ra, ba, sa, dna}, expv(pos_a, md_a, mdone_a));
      end
      if (c <= 14) stream = {stream[12:0], oa};
      if (dna === 1'b1 && done_cyc < 0) done_cyc = c;
      tick();
    end
    checks++;
    if (stream !== 14'b10111010010100) begin
      errors++;
      $display("FAIL single_stream got %b want 10111010010100", stream);
    end
    checks++;
    if (done_cyc != 15) begin
      errors++;
      $display("FAIL single_done_cycle got %0d want 15", done_cyc);
    end
  endtask

  task automatic test_back_to_back();
    logic       exp_q[$];
    logic [29:0] s;
    logic       e;
    int         d1, d2;
    d1 = -1; d2 = -1;
    s = {4'b1011, 8'hFF, 2'b00, 1'b0, 4'b1011, 8'h00, 2'b00, 1'b0};
    for (int i = 29; i >= 0; i--) exp_q.push_back(s[i]);
    va = 1'b1; da = 8'hFF;
    tick();
    da = 8'h00;
    for (int c = 1; c <= 30; c++) begin
      if (c == 16) va = 1'b0;
      checks++;
      if ({oa, ra, ba, sa, dna} !== expv(pos_a, md_a, mdone_a)) begin
        errors++;
        $display("FAIL b2b c=%0d got %b want %b", c, {oa, ra, ba, sa, dna}, expv(pos_a, md_a, mdone_a));
      end
      e = exp_q.pop_front();
      checks++;
      if (oa !== e) begin
        errors++;
        $display("FAIL b2b_stream c=%0d got %b want %b", c, oa, e);
      end
      if (dna === 1'b1) begin
        if (d1 < 0) d1 = c; else if (d2 < 0) d2 = c;
      end
      tick();
    end
    checks++;
    if (d1 != 15 || d2 != 30) begin
      errors++;
      $display("FAIL b2b_period got done at %0d,%0d want 15,30", d1, d2);
    end
  endtask

  task automatic test_ignore_busy();
    logic [7:0] payload;
    payload = '0;
    va = 1'b1; da = 8'h3C;
    tick();
    for (int c = 1; c <= 18; c++) begin
      checks++;
      if ({oa, ra, ba, sa, dna} !== expv(pos_a, md_a, mdone_a)) begin
        errors++;
        $display("FAIL ignore c=%0d got %b want %b", c, {oa, ra, ba, sa, dna}, expv(pos_a, md_a, mdone_a));
      end
      if (c >= 5 && c <= 12) payload = {payload[6:0], oa};
      va = (pos_a != 0 && pos_a != LEN_A) ? 1'($urandom_range(0, 1)) : 1'b0;
      da = 8'hFF;
      tick();
    end
    checks++;
    if (payload !== 8'h3C) begin
      errors++;
      $display("FAIL ignore_payload got %h want 3c", payload);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0]  r;
    logic [13:0] stream, want;
    va = 1'b1; da = 8'($urandom);
    tick();
    va = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      checks++;
      if ({oa, ra, ba, sa, dna} !== expv(pos_a, md_a, mdone_a)) begin
        errors++;
        $display("FAIL midreset_pre c=%0d got %b want %b", c, {oa, ra, ba, sa, dna}, expv(pos_a, md_a, mdone_a));
      end
      if (c < 3) tick();
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if ({oa, ra, ba, sa, dna} !== 5'b01000) begin
      errors++;
      $display("FAIL midreset_after got %b want 01000", {oa, ra, ba, sa, dna});
    end
    tick();
    checks++;
    if (dna !== 1'b0 || ba !== 1'b0) begin
      errors++;
      $display("FAIL midreset_nodone got done=%b busy=%b want 0,0", dna, ba);
    end
    r = 8'($urandom);
    want = {PAT, r, 2'b00};
    stream = '0;
    va = 1'b1; da = r;
    tick();
    va = 1'b0;
    for (int c = 1; c <= 15; c++) begin
      checks++;
      if ({oa, ra, ba, sa, dna} !== expv(pos_a, md_a, mdone_a)) begin
        errors++;
        $display("FAIL midreset_new c=%0d got %b want %b", c, {oa, ra, ba, sa, dna}, expv(pos_a, md_a, mdone_a));
      end
      if (c <= 14) stream = {stream[12:0], oa};
      tick();
    end
    checks++;
    if (stream !== want) begin
      errors++;
      $display("FAIL midreset_stream got %b want %b", stream, want);
    end
  endtask

  task automatic test_gap0();
    logic [7:0]  r;
    logic [25:0] stream, want;
    int          d1, d2;
    d1 = -1; d2 = -1; stream = '0;
    r = 8'($urandom);
    want = {4'b1011, 8'h01, 1'b0, 4'b1011, r, 1'b0};
    vb = 1'b1; db = 8'h01;
    tick();
    db = r;
    for (int c = 1; c <= 26; c++) begin
      if (c == 14) vb = 1'b0;
      checks++;
      if ({ob, rb, bb, sb, dnb} !== expv(pos_b, md_b, mdone_b)) begin
        errors++;
        $display("FAIL gap0 c=%0d got %b want %b", c, {ob, rb, bb, sb, dnb}, expv(pos_b, md_b, mdone_b));
      end
      stream = {stream[24:0], ob};
      if (dnb === 1'b1) begin
        if (d1 < 0) d1 = c; else if (d2 < 0) d2 = c;
      end
      tick();
    end
    checks++;
    if (stream !== want) begin
      errors++;
      $display("FAIL gap0_stream got %b want %b", stream, want);
    end
    checks++;
    if (d1 != 13 || d2 != 26) begin
      errors++;
      $display("FAIL gap0_period got done at %0d,%0d want 13,26", d1, d2);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      reset = ($urandom_range(0, 59) == 0);
      va = 1'($urandom_range(0, 1));
      vb = 1'($urandom_range(0, 1));
      da = 8'($urandom);
      db = 8'($urandom);
      tick();
      checks++;
      if ({oa, ra, ba, sa, dna} !== expv(pos_a, md_a, mdone_a)) begin
        errors++;
        $display("FAIL random_a cyc=%0d got %b want %b", cyc, {oa, ra, ba, sa, dna}, expv(pos_a, md_a, mdone_a));
      end
      checks++;
      if ({ob, rb, bb, sb, dnb} !== expv(pos_b, md_b, mdone_b)) begin
        errors++;
        $display("FAIL random_b cyc=%0d got %b want %b", cyc, {ob, rb, bb, sb, dnb}, expv(pos_b, md_b, mdone_b));
      end
    end
    reset = 1'b0; va = 1'b0; vb = 1'b0;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    reset = 1'b1; va = 1'b0; vb = 1'b0; da = '0; db = '0;
    test_reset();
    test_single();
    test_back_to_back();
    test_ignore_busy();
    test_reset_mid();
    test_gap0();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
